// File: rtl/call_stack.sv
// Return-address stack for the single-cycle CPU: a circular buffer with a top pointer and a count,
// replace-top on simultaneous push/pop, a selectable push-when-full policy and sticky error flags.
module call_stack #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // No handshake: push/pop are sampled at every rising edge and are never stalled.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic [PW-1:0]    top_n;
    logic [CW-1:0]    count_n;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             set_ovf;
    logic             set_unf;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    assign top_inc = (top == PW'(DEPTH-1)) ? '0 : top + PW'(1);
    assign top_dec = (top == '0) ? PW'(DEPTH-1) : top - PW'(1);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : mem[top];

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = top_inc;
        top_n   = top;
        count_n = count;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    top_n   = top_inc;
                    count_n = count + CW'(1);
                end else begin
                    set_ovf = 1'b1;
                    if (OVF_MODE == 1) begin
                        wr_en = 1'b1;
                        top_n = top_inc;
                    end
                end
            end
            2'b01: begin
                if (!empty) begin
                    top_n   = top_dec;
                    count_n = count - CW'(1);
                end else begin
                    set_unf = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Replace-top: a return immediately followed by a call, never an overflow.
                    wr_en  = 1'b1;
                    wr_idx = top;
                end else begin
                    set_unf = 1'b1;
                    wr_en   = 1'b1;
                    top_n   = top_inc;
                    count_n = CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            top   <= top_n;
            count <= count_n;
            // An error event in the same cycle as clr_err keeps the flag set.
            if (set_ovf)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (set_unf)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: two instances (drop and circular overflow policy) driven in lockstep
// and checked every cycle against a queue-based stack model through an expected-state scoreboard.
module tb_call_stack;
    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int SW    = WIDTH + CW + 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] din = '0;

    logic [WIDTH-1:0] dout0, dout1;
    logic [CW-1:0]    count0, count1;
    logic             empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

    int checks = 0;
    int errors = 0;

    logic [2*SW-1:0]  exp_q[$];
    logic [WIDTH-1:0] stk[2][$];
    bit               m_ovf[2];
    bit               m_unf[2];

    always #5 clk = ~clk;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
        .dout(dout0), .count(count0), .empty(empty0), .full(full0),
        .overflow(ovf0), .underflow(unf0)
    );

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
        .dout(dout1), .count(count1), .empty(empty1), .full(full1),
        .overflow(ovf1), .underflow(unf1)
    );

    wire [SW-1:0] act0 = {dout0, count0, empty0, full0, ovf0, unf0};
    wire [SW-1:0] act1 = {dout1, count1, empty1, full1, ovf1, unf1};

    // Expected observable state of instance m, derived from the reference stack.
    function automatic logic [SW-1:0] exp_word(input int m);
        int n;
        logic [WIDTH-1:0] t;
        n = stk[m].size();
        t = (n == 0) ? '0 : stk[m][n-1];
        return {t, CW'(n), (n == 0), (n == DEPTH), m_ovf[m], m_unf[m]};
    endfunction

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual {dout,count,empty,full,ovf,unf}=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        for (int m = 0; m < 2; m++) begin
            bit ovf_ev;
            bit unf_ev;
            int n;
            ovf_ev = 0;
            unf_ev = 0;
            n = stk[m].size();
            if (p && q) begin
                if (n == 0) begin
                    unf_ev = 1;
                    stk[m].push_back(d);
                end else begin
                    stk[m][n-1] = d;
                end
            end else if (p) begin
                if (n < DEPTH) stk[m].push_back(d);
                else begin
                    ovf_ev = 1;
                    if (m == 1) begin
                        void'(stk[m].pop_front());
                        stk[m].push_back(d);
                    end
                end
            end else if (q) begin
                if (n == 0) unf_ev = 1;
                else void'(stk[m].pop_back());
            end
            if (ovf_ev) m_ovf[m] = 1;
            else if (c) m_ovf[m] = 0;
            if (unf_ev) m_unf[m] = 1;
            else if (c) m_unf[m] = 0;
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        @(negedge clk);
        push = p;
        pop = q;
        din = d;
        clr_err = c;
        model(p, q, d, c);
        exp_q.push_back({exp_word(1), exp_word(0)});
        @(posedge clk);
        #2;
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            stk[m].delete();
            m_ovf[m] = 0;
            m_unf[m] = 0;
        end
        check("reset0", act0, exp_word(0));
        check("reset1", act1, exp_word(1));
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        logic [2*SW-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("drop_mode", act0, e[SW-1:0]);
            check("circ_mode", act1, e[2*SW-1:SW]);
        end
    end

    initial begin
        do_reset();

        // Basic LIFO order.
        step(1, 0, 10'h011, 0);
        step(1, 0, 10'h022, 0);
        step(1, 0, 10'h033, 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);

        // Fill, then push while full under both policies, then drain.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1, 0, WIDTH'(i), 0);
        for (int i = 0; i < 4; i++) step(0, 1, '0, 0);

        // Underflow, clear racing a new error, then plain clear.
        do_reset();
        step(0, 1, '0, 0);
        step(0, 1, '0, 1);
        step(0, 0, '0, 1);

        // Replace-top on a single entry and on a full stack; push+pop on empty.
        do_reset();
        step(1, 0, 10'h0A0, 0);
        step(1, 1, 10'h0B0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, WIDTH'(10'h0C0 + i), 0);
        step(1, 1, 10'h0D0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, '0, 0);
        step(1, 1, 10'h0E0, 0);

        // Reset mid-operation, then a normal push.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, WIDTH'(10'h100 + i), 0);
        do_reset();
        step(1, 0, 10'h155, 0);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45,
                      WIDTH'($urandom), $urandom_range(0, 19) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the single-cycle CPU family. It replaces the fixed subroutine stack inside the datapath with a configurable block that has:
- width and depth parameters;
- a selectable overflow policy;
- simultaneous push/pop (replace-top);
- occupancy output and sticky error flags.

The datapath drives `push` on a call and `pop` on a return. `dout` feeds the PC-source mux in the same cycle as `pop`.

## Interface
- `WIDTH`, default 10: bits per entry (program-counter width).
- `DEPTH`, default 16: number of entries, at least 2.
- `OVF_MODE`, default 0: push-when-full policy. 0 = drop the push. 1 = circular, overwrite the oldest entry.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `push`  input  1  push `din` this cycle.
- `pop`  input  1  pop top entry this cycle.
- `din`  input  WIDTH  value to push (return address).
- `clr_err`  input  1  clears the sticky `overflow`/`underflow` flags.
- `dout`  output  WIDTH  current top entry; 0 when empty.
- `count`  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `overflow`  output  1  sticky; set by a push while full.
- `underflow`  output  1  sticky; set by a pop while empty.

## Operation
- Storage: DEPTH×WIDTH register array used as a circular buffer.
  - `top` pointer (index of the newest entry), plus `count`.
  - Pointers wrap modulo DEPTH. When DEPTH is not a power of two, wrap explicitly.
- `push` only, not full: write `din` at `top+1`, advance `top`, increment `count`.
- `push` only, full:
  - `OVF_MODE` 0: stack unchanged; set `overflow`.
  - `OVF_MODE` 1: write at `top+1`, advance `top`, overwriting the oldest entry; `count` stays DEPTH; set `overflow`.
- `pop` only, not empty: retreat `top`, decrement `count`. The popped value is the `dout` presented during that cycle.
- `pop` only, empty: no state change; set `underflow`.
- `push` and `pop`, not empty: replace-top. Write `din` at `top`; `top` and `count` unchanged; no flag set. This applies even when full (no overflow).
- `push` and `pop`, empty: set `underflow`; push `din` (`count` becomes 1).
- Neither asserted: hold.
- `clr_err` clears both sticky flags at the next edge. If an error event occurs in the same cycle, the set wins.
- `dout` is combinational from registered state: `mem[top]` when `count != 0`, else 0. No input-to-output combinational path.
- Array contents are not reset. Only pointers, count and flags are.

## Timing
- Reset (async assert, any time, including mid-operation): `top`=0, `count`=0. Outputs become `dout`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0 without waiting for a clock edge.
- Reset release: the first operative edge is the first rising `clk` after `reset` deasserts.
- Read latency: 0 cycles. `dout` reflects the top in the same cycle `pop` is asserted, so a return is single-cycle.
- Write latency: 1 cycle. The value pushed at edge N appears on `dout` after edge N, and `count`/`full`/`empty` update at the same edge.
- Flags rise on the edge that processes the offending request. They remain high until `clr_err` or `reset`.
- One operation per cycle. No handshake; requests are never stalled.

## Test plan
WIDTH=10, DEPTH=4 unless stated.
- Reset, then push 0x011, 0x022, 0x033 -> `count`=3, `dout`=0x033. Pop ×3 -> `dout` sequence 0x033, 0x022, 0x011, then `empty`=1, `dout`=0; no flags set.
- Fill to 4 (0x1..0x4), then push 0x5 with `OVF_MODE`=0 -> `overflow`=1, `count`=4, `dout`=0x4. Pop ×4 yields 0x4, 0x3, 0x2, 0x1.
- Same sequence with `OVF_MODE`=1 -> `overflow`=1, `count`=4, `dout`=0x5. Pop ×4 yields 0x5, 0x4, 0x3, 0x2.
- Empty stack: pop -> `underflow`=1, `count`=0. Then `clr_err` concurrent with another pop -> `underflow` stays 1. Then `clr_err` alone -> `underflow`=0.
- Push 0x0A0, then `push`+`pop` with `din`=0x0B0 -> `count`=1, `dout`=0x0B0, no flags. Repeat on a full stack -> `count`=4, `overflow`=0.
- Assert `reset` asynchronously between edges with `count`=3 -> `count`=0, `empty`=1, `dout`=0, flags 0 immediately. The first push after release lands normally (`count`=1).
